// File: rtl/i_cache_sa_if.sv
// rtl/i_cache_sa_if.sv - fetch-side and IRAM-side signal bundle of the set-associative i-cache
interface i_cache_sa_if #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int CNT_W      = 32
);
  logic                  fetch_req;
  logic [PC_SIZE-1:0]    pc;
  logic                  flush;
  logic                  hit;
  logic                  stall;
  logic [INSTR_SIZE-1:0] fetched_inst;
  logic                  mem_req;
  logic [PC_SIZE-1:0]    mem_addr;
  logic                  mem_valid;
  logic [0:BLOCK_SIZE-1] block_in;
  logic [CNT_W-1:0]      miss_count;

  modport slave (
    input  fetch_req, pc, flush, mem_valid, block_in,
    output hit, stall, fetched_inst, mem_req, mem_addr, miss_count
  );

  modport master (
    output fetch_req, pc, flush, mem_valid, block_in,
    input  hit, stall, fetched_inst, mem_req, mem_addr, miss_count
  );
endinterface

// File: rtl/i_cache_sa.sv
// rtl/i_cache_sa.sv - N-way set-associative instruction cache with refill FSM,
// round-robin victim choice, set-by-set invalidation and saturating miss counter.
module i_cache_sa #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int NUM_SETS   = 16,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          nrst,
  i_cache_sa_if.slave   bus
);
  localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = PC_SIZE - OFF_W - SET_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WIDX_W = OFF_W - 2;

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;
  state_t state_q, state_d;

  logic                   valid_q [NUM_SETS][WAYS];
  logic [TAG_W-1:0]       tag_q   [NUM_SETS][WAYS];
  logic [0:BLOCK_SIZE-1]  data_q  [NUM_SETS][WAYS];
  logic [WAY_W-1:0]       rr_q    [NUM_SETS];
  logic [CNT_W-1:0]       miss_count_q;
  logic [TAG_W+SET_W-1:0] line_q, line_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [SET_W-1:0]       fset_q, fset_d;

  logic [SET_W-1:0]       set_idx, r_set;
  logic [TAG_W-1:0]       tag_idx, r_tag;
  logic [WIDX_W-1:0]      word_idx;
  logic                   lookup_hit, victim_free;
  logic [WAY_W-1:0]       hit_way, victim;
  logic [0:BLOCK_SIZE-1]  hit_line;
  logic [INSTR_SIZE-1:0]  word;
  logic                   hit, stall, mem_req, refill_we, flush_clr, miss_inc;
  logic [PC_SIZE-1:0]     mem_addr;

  assign set_idx  = bus.pc[OFF_W +: SET_W];
  assign tag_idx  = bus.pc[PC_SIZE-1 -: TAG_W];
  assign word_idx = bus.pc[2 +: WIDX_W];
  assign r_set    = line_q[SET_W-1:0];
  assign r_tag    = line_q[TAG_W+SET_W-1 -: TAG_W];

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_idx)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  // Line bytes arrive in ascending order; an instruction word is little-endian over them.
  always_comb begin
    hit_line = data_q[set_idx][hit_way];
    word     = '0;
    for (int b = 0; b < 4; b++) begin
      word[8*b +: 8] = hit_line[32*int'(word_idx) + 8*b +: 8];
    end
  end

  // Descending scan so the lowest-index free way wins.
  always_comb begin
    victim      = rr_q[r_set];
    victim_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[r_set][w]) begin
        victim      = WAY_W'(w);
        victim_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q;
    fset_d       = fset_q;
    hit          = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    refill_we    = 1'b0;
    flush_clr    = 1'b0;
    miss_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        hit   = bus.fetch_req & lookup_hit;
        stall = bus.fetch_req & ~lookup_hit;
        if (bus.flush) begin
          state_d = FLUSH;
          fset_d  = '0;
        end else if (bus.fetch_req && !lookup_hit) begin
          state_d  = REFILL;
          line_d   = bus.pc[PC_SIZE-1:OFF_W];
          miss_inc = 1'b1;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {line_q, {OFF_W{1'b0}}};
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_valid) begin
          refill_we    = 1'b1;
          flush_pend_d = 1'b0;
          fset_d       = '0;
          state_d      = (flush_pend_q || bus.flush) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        stall     = 1'b1;
        flush_clr = 1'b1;
        fset_d    = fset_q + 1'b1;
        if (fset_q == SET_W'(NUM_SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      fset_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      fset_q       <= fset_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
        end
      end
      miss_count_q <= '0;
    end else begin
      if (miss_inc && (miss_count_q != '1)) miss_count_q <= miss_count_q + 1'b1;
      if (refill_we) begin
        valid_q[r_set][victim] <= 1'b1;
        tag_q[r_set][victim]   <= r_tag;
        data_q[r_set][victim]  <= bus.block_in;
        // The pointer only advances when it actually chose the victim.
        if (!victim_free) begin
          rr_q[r_set] <= (rr_q[r_set] == WAY_W'(WAYS - 1)) ? '0 : rr_q[r_set] + 1'b1;
        end
      end
      if (flush_clr) begin
        rr_q[fset_q] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[fset_q][w] <= 1'b0;
      end
    end
  end

  assign bus.hit          = hit;
  assign bus.stall        = stall;
  assign bus.fetched_inst = hit ? word : '0;
  assign bus.mem_req      = mem_req;
  assign bus.mem_addr     = mem_addr;
  assign bus.miss_count   = miss_count_q;
endmodule

// File: tb/tb_i_cache_sa.sv
// tb/tb_i_cache_sa.sv - scoreboard bench for i_cache_sa against a line-level cache model
module tb_i_cache_sa;
  localparam int NS = 16;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  i_cache_sa_if #(.PC_SIZE(32), .INSTR_SIZE(32), .BLOCK_SIZE(128), .CNT_W(32)) bus ();
  i_cache_sa_if #(.PC_SIZE(32), .INSTR_SIZE(32), .BLOCK_SIZE(128), .CNT_W(4))  bus4 ();

  assign bus4.fetch_req = bus.fetch_req;
  assign bus4.pc        = bus.pc;
  assign bus4.flush     = bus.flush;
  assign bus4.mem_valid = bus.mem_valid;
  assign bus4.block_in  = bus.block_in;

  i_cache_sa #(.PC_SIZE(32), .INSTR_SIZE(32), .BLOCK_SIZE(128), .NUM_SETS(NS), .WAYS(NW), .CNT_W(32))
    dut (.clk(clk), .nrst(nrst), .bus(bus));
  i_cache_sa #(.PC_SIZE(32), .INSTR_SIZE(32), .BLOCK_SIZE(128), .NUM_SETS(NS), .WAYS(NW), .CNT_W(4))
    dut4 (.clk(clk), .nrst(nrst), .bus(bus4));

  typedef struct {
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] mc;
    logic [3:0]  mc4;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  // Model: each way remembers which line address it holds.
  int unsigned m_line  [NS][NW];
  bit          m_valid [NS][NW];
  int          m_rr    [NS];
  int          m_mode;
  int          m_fcnt;
  bit          m_fpend;
  int unsigned m_pend;
  int          m_misses;
  bit          last_stall;

  function automatic logic [7:0] mbyte(input int unsigned line, input int k);
    return 8'((line >> 4) * 29 + k * 17 + 3);
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned line, input int w);
    return {mbyte(line, 4*w+3), mbyte(line, 4*w+2), mbyte(line, 4*w+1), mbyte(line, 4*w)};
  endfunction

  function automatic logic [0:127] make_block(input int unsigned line);
    logic [0:127] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = mbyte(line, k);
    return b;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'(($urandom_range(0, 5) << 8) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_line[s][w]  = 0;
      end
    end
    m_mode = 0; m_fcnt = 0; m_fpend = 1'b0; m_pend = 0; m_misses = 0; last_stall = 1'b0;
  endtask

  task automatic step(input bit fr, input logic [31:0] a, input bit fl, input bit mv);
    exp_t e;
    int s, hitw, v;
    @(posedge clk);
    #1;
    bus.fetch_req = fr;
    bus.pc        = a;
    bus.flush     = fl;
    bus.mem_valid = mv;
    bus.block_in  = mv ? make_block(m_pend) : {$urandom, $urandom, $urandom, $urandom};
    e.hit = 1'b0; e.stall = 1'b0; e.mem_req = 1'b0; e.inst = '0; e.addr = '0;
    e.mc  = 32'(m_misses);
    e.mc4 = (m_misses > 15) ? 4'd15 : 4'(m_misses);
    case (m_mode)
      0: begin
        s = int'((a >> 4) & 32'hF);
        hitw = -1;
        for (int w = 0; w < NW; w++)
          if (m_valid[s][w] && m_line[s][w] == (a & ~32'hF)) hitw = w;
        e.hit   = fr && (hitw >= 0);
        e.stall = fr && (hitw < 0);
        if (e.hit) e.inst = exp_word(a & ~32'hF, int'((a >> 2) & 32'h3));
        if (fl) begin
          m_mode = 2; m_fcnt = NS;
        end else if (fr && hitw < 0) begin
          m_misses++; m_pend = a & ~32'hF; m_mode = 1;
        end
      end
      1: begin
        e.stall = 1'b1; e.mem_req = 1'b1; e.addr = m_pend;
        if (fl) m_fpend = 1'b1;
        if (mv) begin
          s = int'((m_pend >> 4) & 32'hF);
          v = -1;
          for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
          if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NW;
          end
          m_valid[s][v] = 1'b1;
          m_line[s][v]  = m_pend;
          if (m_fpend) begin m_mode = 2; m_fcnt = NS; end
          else m_mode = 0;
          m_fpend = 1'b0;
        end
      end
      default: begin
        e.stall = 1'b1;
        m_fcnt--;
        if (m_fcnt == 0) begin
          for (int i = 0; i < NS; i++) begin
            m_rr[i] = 0;
            for (int w = 0; w < NW; w++) m_valid[i][w] = 1'b0;
          end
          m_mode = 0;
        end
      end
    endcase
    last_stall = e.stall;
    expq.push_back(e);
  endtask

  // Hold the request until it is served; IRAM answers lat cycles into the refill.
  task automatic fetch(input logic [31:0] a, input int lat, input bit flush_in_refill);
    int l, guard;
    bit mv, fl, fpl;
    l = lat; guard = 0; fpl = flush_in_refill;
    do begin
      mv = 1'b0; fl = 1'b0;
      if (m_mode == 1) begin
        if (fpl) begin fl = 1'b1; fpl = 1'b0; end
        if (l == 0) mv = 1'b1;
        else l--;
      end
      step(1'b1, a, fl, mv);
      guard++;
    end while (last_stall && guard < 100);
    if (guard >= 100) chk("fetch_bound", 32'(guard), 32'd99);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("hit",          32'(bus.hit),      32'(e.hit));
        chk("stall",        32'(bus.stall),    32'(e.stall));
        chk("mem_req",      32'(bus.mem_req),  32'(e.mem_req));
        chk("fetched_inst", bus.fetched_inst,  e.inst);
        chk("mem_addr",     bus.mem_addr,      e.addr);
        chk("miss_count",   bus.miss_count,    e.mc);
        chk("miss_count4",  32'(bus4.miss_count), 32'(e.mc4));
      end
    end
  end

  initial begin
    int r;
    bus.fetch_req = 1'b0; bus.pc = '0; bus.flush = 1'b0; bus.mem_valid = 1'b0; bus.block_in = '0;
    model_reset();
    #3;
    chk("rst_hit",     32'(bus.hit),     32'd0);
    chk("rst_stall",   32'(bus.stall),   32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_addr",    bus.mem_addr,     32'd0);
    chk("rst_inst",    bus.fetched_inst, 32'd0);
    chk("rst_count",   bus.miss_count,   32'd0);
    #9 nrst = 1'b1;

    fetch(32'h100, 1, 1'b0);
    fetch(32'h104, 0, 1'b0);
    fetch(32'h108, 0, 1'b0);
    fetch(32'h10C, 0, 1'b0);

    fetch(32'h000, 2, 1'b1);
    fetch(32'h100, 0, 1'b0);

    fetch(32'h200, 1, 1'b0);
    fetch(32'h100, 0, 1'b0);
    fetch(32'h000, 0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) step(1'b0, $urandom, 1'b0, 1'b0);
      else if (r == 1) step(1'b0, 32'h0, 1'b1, 1'b0);
      else fetch(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    fetch(32'h000, 0, 1'b0);
    @(negedge clk);
    #1;
    if (m_misses >= 20) chk("mc4_saturated", 32'(bus4.miss_count), 32'd15);

    step(1'b1, 32'h7F0, 1'b0, 1'b0);
    step(1'b1, 32'h7F0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("async_mem_req", 32'(bus.mem_req),  32'd0);
    chk("async_addr",    bus.mem_addr,      32'd0);
    chk("async_count",   bus.miss_count,    32'd0);
    bus.fetch_req = 1'b0; bus.flush = 1'b0; bus.mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    fetch(32'h7F0, 1, 1'b0);
    fetch(32'h7F4, 0, 1'b0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
